// File: rtl/life_pkg.sv
`timescale 1ns/1ps
// Shared types for the Game of Life generation sequencer.
package life_pkg;

    localparam int GRID_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_STILL   = 2'd1,
        HC_EXTINCT = 2'd2,
        HC_OSC2    = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/life_sequencer_rate_divider.sv
`timescale 1ns/1ps
// Free-run rate divider: while enabled, asserts tick once every period+1 cycles.
module rate_divider #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] div;

    // >= rather than == so lowering period mid-run cannot strand div above it
    assign tick = en && (div >= period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (clr || tick) begin
            div <= '0;
        end else if (en) begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/life_sequencer.sv
`timescale 1ns/1ps
// Generation controller: owns the committed grid, sequences load/run/step/halt,
// counts generations and stops on extinction, still life or period-2 oscillation.
module life_sequencer #(
    parameter int GRID_W = life_pkg::GRID_W,
    parameter int DIV_W  = 24,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_seed,
    input  logic [GRID_W-1:0] seed,
    input  logic              rand_load,
    input  logic [GRID_W-1:0] lfsr_in,
    input  logic              run,
    input  logic              step,
    input  logic              auto_halt,
    input  logic [DIV_W-1:0]  period,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              gen_tick,
    output logic [1:0]        state_o,
    output logic [1:0]        halt_cause
);
    import life_pkg::*;

    seq_state_t        state_q, state_d;
    halt_cause_t       cause_q, hit_cause;
    logic [GRID_W-1:0] prev_grid;
    logic              prev_valid;
    logic              load, div_en, div_clr, tick, commit, hit;
    logic [GRID_W-1:0] load_val;

    assign load     = load_seed | rand_load;
    assign load_val = load_seed ? seed : lfsr_in;
    assign div_en   = (state_q == S_RUN) && run;
    assign div_clr  = load || ((state_q == S_IDLE) && run);
    // A divider tick while run has dropped is discarded by div_en
    assign commit   = !load && ((div_en && tick) || (state_q == S_STEP));

    rate_divider #(.DIV_W(DIV_W)) u_div (
        .clk    (clk),
        .reset  (reset),
        .en     (div_en),
        .clr    (div_clr),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        hit_cause = HC_NONE;
        if (auto_halt) begin
            if (next_grid == '0)
                hit_cause = HC_EXTINCT;
            else if (next_grid == grid)
                hit_cause = HC_STILL;
            else if (prev_valid && (next_grid == prev_grid))
                hit_cause = HC_OSC2;
        end
    end

    assign hit = commit && (hit_cause != HC_NONE);

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = run ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (run) state_d = S_RUN;
                        else if (step) state_d = S_STEP;
                S_RUN:  if (!run) state_d = S_IDLE;
                        else if (hit) state_d = S_HALT;
                S_STEP: state_d = hit ? S_HALT : S_IDLE;
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cause_q    <= HC_NONE;
            grid       <= '0;
            prev_grid  <= '0;
            prev_valid <= 1'b0;
            gen_count  <= '0;
            gen_tick   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gen_tick <= commit;
            if (load) begin
                grid       <= load_val;
                gen_count  <= '0;
                cause_q    <= HC_NONE;
                prev_valid <= 1'b0;
            end else if (commit) begin
                prev_grid  <= grid;
                grid       <= next_grid;
                prev_valid <= 1'b1;
                if (gen_count != '1)
                    gen_count <= gen_count + GEN_W'(1);
                if (hit)
                    cause_q <= hit_cause;
            end
        end
    end

    assign state_o    = state_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_life_sequencer.sv
`timescale 1ns/1ps
// Directed bench for life_sequencer; a small Life model stands in for the datapath.
module tb_life_sequencer;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] LFSR    = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_seed = 1'b0, rand_load = 1'b0, run = 1'b0, step = 1'b0, auto_halt = 1'b0;
    logic [63:0] seed = '0, lfsr_in = '0;
    logic [23:0] period = '0;
    logic [63:0] next_grid, grid;
    logic [15:0] gen_count;
    logic        gen_tick;
    logic [1:0]  state_o, halt_cause;

    logic        load2 = 1'b0, run2 = 1'b0;
    logic [63:0] next_grid2, grid2;
    logic [3:0]  gen_count2;
    logic        gen_tick2;
    logic [1:0]  state2, cause2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            cnt += int'(g[(r + dr) * 8 + c + dc]);
                n[r * 8 + c] = (cnt == 3) || (cnt == 2 && g[r * 8 + c]);
            end
        end
        return n;
    endfunction

    assign next_grid  = life_next(grid);
    assign next_grid2 = life_next(grid2);

    life_sequencer dut (
        .clk(clk), .reset(reset), .load_seed(load_seed), .seed(seed),
        .rand_load(rand_load), .lfsr_in(lfsr_in), .run(run), .step(step),
        .auto_halt(auto_halt), .period(period), .next_grid(next_grid),
        .grid(grid), .gen_count(gen_count), .gen_tick(gen_tick),
        .state_o(state_o), .halt_cause(halt_cause)
    );

    life_sequencer #(.GEN_W(4)) dut_sat (
        .clk(clk), .reset(reset), .load_seed(load2), .seed(BLINK_H),
        .rand_load(1'b0), .lfsr_in(64'h0), .run(run2), .step(1'b0),
        .auto_halt(1'b0), .period(24'd0), .next_grid(next_grid2),
        .grid(grid2), .gen_count(gen_count2), .gen_tick(gen_tick2),
        .state_o(state2), .halt_cause(cause2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        chk("rst_grid", grid, 64'h0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_tick", 64'(gen_tick), 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_cause", 64'(halt_cause), 64'd0);

        // Async reset in the middle of a free run
        seed = BLINK_H; load_seed = 1'b1; run = 1'b1;
        cyc();
        load_seed = 1'b0;
        cyc(5);
        chk("mid_gen5", 64'(gen_count), 64'd5);
        chk("mid_grid", grid, BLINK_V);
        reset = 1'b1;
        #1;
        chk("arst_grid", grid, 64'h0);
        chk("arst_gen", 64'(gen_count), 64'd0);
        chk("arst_state", 64'(state_o), 64'd0);
        chk("arst_cause", 64'(halt_cause), 64'd0);
        cyc();
        reset = 1'b0;

        // Blinker halts as period-2 oscillator
        auto_halt = 1'b1; seed = BLINK_H; load_seed = 1'b1; run = 1'b1;
        cyc();
        load_seed = 1'b0;
        chk("bl_load", grid, BLINK_H);
        chk("bl_state0", 64'(state_o), 64'd1);
        cyc();
        chk("bl_g1", grid, BLINK_V);
        chk("bl_gen1", 64'(gen_count), 64'd1);
        chk("bl_tick1", 64'(gen_tick), 64'd1);
        cyc();
        chk("bl_g2", grid, BLINK_H);
        chk("bl_gen2", 64'(gen_count), 64'd2);
        chk("bl_state", 64'(state_o), 64'd3);
        chk("bl_cause", 64'(halt_cause), 64'd3);
        cyc(2);
        chk("bl_frozen", grid, BLINK_H);
        chk("bl_gen_hold", 64'(gen_count), 64'd2);
        run = 1'b0;

        // Block still life via single step
        seed = BLOCK; load_seed = 1'b1;
        cyc();
        load_seed = 1'b0;
        chk("blk_idle", 64'(state_o), 64'd0);
        chk("blk_cause_clr", 64'(halt_cause), 64'd0);
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("blk_stepst", 64'(state_o), 64'd2);
        cyc();
        chk("blk_gen", 64'(gen_count), 64'd1);
        chk("blk_state", 64'(state_o), 64'd3);
        chk("blk_cause", 64'(halt_cause), 64'd1);
        chk("blk_grid", grid, BLOCK);

        // Extinction, then step ignored in HALT
        seed = SINGLE; load_seed = 1'b1;
        cyc();
        load_seed = 1'b0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        chk("ext_grid", grid, 64'h0);
        chk("ext_cause", 64'(halt_cause), 64'd2);
        step = 1'b1;
        cyc(2);
        step = 1'b0;
        chk("ext_state", 64'(state_o), 64'd3);
        chk("ext_gen", 64'(gen_count), 64'd1);

        // Rate: period=3 gives a tick every 4 cycles
        auto_halt = 1'b0; period = 24'd3; seed = BLINK_H; load_seed = 1'b1; run = 1'b1;
        cyc();
        load_seed = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk($sformatf("rate_k%0d", k), 64'(gen_tick), 64'((k % 4) == 0));
        end
        chk("rate_gen", 64'(gen_count), 64'd4);
        chk("rate_cause", 64'(halt_cause), 64'd0);
        cyc(3);
        run = 1'b0;
        cyc();
        chk("drop_gen", 64'(gen_count), 64'd4);
        chk("drop_tick", 64'(gen_tick), 64'd0);
        chk("drop_state", 64'(state_o), 64'd0);

        // Priority: seed beats rand_load, then rand_load alone
        seed = BLOCK; lfsr_in = LFSR; load_seed = 1'b1; rand_load = 1'b1;
        cyc();
        load_seed = 1'b0;
        chk("pri_grid", grid, BLOCK);
        chk("pri_gen", 64'(gen_count), 64'd0);
        cyc();
        rand_load = 1'b0;
        chk("rand_grid", grid, LFSR);

        // Generation counter saturation on the narrow instance
        load2 = 1'b1; run2 = 1'b1;
        cyc();
        load2 = 1'b0;
        cyc(14);
        chk("sat_e", 64'(gen_count2), 64'hE);
        chk("sat_grid", grid2, BLINK_H);
        cyc(6);
        chk("sat_f", 64'(gen_count2), 64'hF);
        chk("sat_tick", 64'(gen_tick2), 64'd1);
        chk("sat_state", 64'(state2), 64'd1);
        chk("sat_cause", 64'(cause2), 64'd0);
        run2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Generation controller for the 64-cell Game of Life engine.
- Owns the committed grid register and sequences the combinational next-generation datapath.
- Supports seed load, LFSR-random load, free-run at a programmable rate, single-step and pause.
- Counts generations and auto-halts on extinction, still life or period-2 oscillation.
- Sits between the top-level button FSM and the datapath/LFSR, replacing ad-hoc grid muxing.

Parameters:
GRID_W, 64, cell count; cell (r,c) is grid[r*8+c].
DIV_W, 24, width of rate divider and period input.
GEN_W, 16, width of generation counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_seed  in  1  pulse: load seed into grid
seed  in  GRID_W  user seed pattern
rand_load  in  1  pulse: load lfsr_in into grid
lfsr_in  in  GRID_W  current LFSR value
run  in  1  level: free-run enable
step  in  1  pulse: single generation (honoured only in IDLE)
auto_halt  in  1  enable halt detection
period  in  DIV_W  cycles between updates minus 1 (0 = every cycle)
next_grid  in  GRID_W  datapath result for current grid
grid  out  GRID_W  committed grid, drives datapath input
gen_count  out  GEN_W  generations since last load
gen_tick  out  1  one-cycle pulse on every committed update
state_o  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
halt_cause  out  2  NONE=0, STILL=1, EXTINCT=2, OSC2=3

Behaviour:
- Reset (async): grid=0, gen_count=0, gen_tick=0, state IDLE, halt_cause NONE, div=0, prev_grid=0, prev_valid=0.
- Command priority per cycle: load_seed > rand_load > run/step. Simultaneous load_seed and rand_load: seed wins.
- Load (any state): grid<=seed/lfsr_in next edge; gen_count<=0, halt_cause<=NONE, prev_valid<=0, div<=0. State becomes RUN if run=1, else IDLE.
- IDLE: run=1 -> RUN (div cleared); step=1 -> STEP; grid held.
- RUN: div counts 0..period; tick when div==period, then div<=0. run=0 -> IDLE at next edge; a tick coinciding with run=0 is discarded (no update).
- STEP: commit exactly one update next edge -> IDLE. run and step ignored while in STEP.
- Commit (RUN tick or STEP):
  - prev_grid<=grid; grid<=next_grid; prev_valid<=1.
  - gen_count saturating increment; stays at all-ones.
  - gen_tick=1 in the cycle after the edge.
- Latency: load to visible grid 1 cycle; period=N gives one update per N+1 cycles.
- Halt check at commit, only if auto_halt=1, in priority order:
  1. next_grid==0 -> EXTINCT.
  2. next_grid==grid -> STILL.
  3. prev_valid && next_grid==prev_grid -> OSC2.
  - On match: commit still performed, state -> HALT, halt_cause latched.
- HALT: grid frozen; run/step ignored. Exit only via load, rand_load or reset.
- auto_halt=0: no halting; halt_cause stays NONE.
- Reset mid-run: immediate async clear to reset values.

Decomposition:
- Package life_pkg:
  - GRID_W constant.
  - seq_state_t enum (IDLE/RUN/STEP/HALT).
  - halt_cause_t enum (NONE/STILL/EXTINCT/OSC2).
- Sub-module rate_divider (clk, reset, en, clr, period -> tick) holds the div counter.
- Halt comparators stay inline.

Test Plan:
- Reset check: assert reset mid-run with gen_count=5 -> grid=0, gen_count=0, state_o=0, halt_cause=0 with no clock edge.
- Blinker, auto_halt=1, period=0: load seed 64'h0000_0000_1C00_0000, run=1 -> grid alternates with 64'h0000_0008_0808_0000. After 2nd commit: HALT, halt_cause=3, gen_count=2.
- Block still life: load 64'h0000_0018_1800_0000, step -> gen_count=1, state_o=3, halt_cause=1, grid unchanged.
- Extinction: load single cell 64'h0000_0000_0800_0000, step -> grid=0, halt_cause=2. A second step stays in HALT with gen_count=1.
- Rate and priority:
  - period=3, auto_halt=0, blinker running -> gen_tick exactly every 4 cycles.
  - rand_load with lfsr_in=64'hDEAD_BEEF_0123_4567 together with load_seed -> grid=seed, gen_count=0.
- Saturation: GEN_W override 4, auto_halt=0, run 20 ticks -> gen_count holds 4'hF.
